uart_tx: RTL
============

UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 16, meaning clock cycles per serial bit.
REQ-002 The block SHALL have parameter ADDR_MAX, default 29999, meaning the last value of tx_addr before it wraps.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port tx_data, input, 8 bits: the byte to send.
REQ-006 The block SHALL have port tx_valid, input, 1 bit: tx_data is valid.
REQ-007 The block SHALL have port tx_ready, output, 1 bit: the block can accept a byte.
REQ-008 The block SHALL have port txd, output, 1 bit: the serial line, idle high.
REQ-009 The block SHALL have port tx_done, output, 1 bit: one-cycle pulse when a frame completes.
REQ-010 The block SHALL have port tx_addr, output, 15 bits: the count of bytes sent, used as the source memory read address.

Function
REQ-011 Frame format SHALL be 8N1: start bit 0, data bits LSB first, stop bit 1, with each bit driven for exactly CLKS_PER_BIT cycles.
REQ-012 The FSM SHALL have states IDLE, START, DATA and STOP; in any other encoding it SHALL go to IDLE.
REQ-013 Acceptance SHALL occur on a rising edge where tx_valid=1 and tx_ready=1; tx_data is latched into an internal shift register at that edge.
REQ-014 tx_ready SHALL be 1 only in IDLE and SHALL be registered; tx_valid while tx_ready=0 SHALL be ignored and SHALL NOT be queued.
REQ-015 Taking the acceptance edge as cycle 0, txd SHALL be 0 in cycles 1..16, data bit i in cycles 17+16i..32+16i, and 1 in cycles 145..160 (values shown for CLKS_PER_BIT=16).
REQ-016 At the end of cycle 160 the FSM SHALL return to IDLE; in cycle 161 tx_done SHALL be 1 for that single cycle, and tx_ready SHALL be 1.
REQ-017 Back-to-back frames SHALL be supported: acceptance in cycle 161 SHALL give a start bit in cycle 162, with no extra idle bit.
REQ-018 Changes to tx_data or tx_valid during a frame SHALL NOT affect the frame in flight.
REQ-019 tx_addr SHALL increment at the edge where tx_done is asserted; if tx_addr equals ADDR_MAX it SHALL instead wrap to 0.
REQ-020 The bit-cycle counter SHALL count 0..CLKS_PER_BIT-1, and its width SHALL be $clog2(CLKS_PER_BIT); the bit index SHALL be 3 bits, 0..7.
REQ-021 txd SHALL come directly from a flop, so it is glitch-free.

Reset
REQ-022 While rst=1 at a rising edge, the block SHALL go to IDLE and set txd=1, tx_ready=1, tx_done=0, tx_addr=0, and clear all counters and the shift register.
REQ-023 Reset during a frame SHALL abort the frame: txd SHALL be 1 from the edge after rst is sampled, and no tx_done SHALL follow.
REQ-024 If rst=1 and tx_valid=1 on the same edge, reset SHALL win and the byte SHALL NOT be accepted.

Structure
REQ-025 Shared package uart_pkg SHALL hold the FSM state typedef, the DATA_BITS=8 constant and the default CLKS_PER_BIT=16, and the future receiver rework SHALL share it.
REQ-026 The design SHALL have one sub-module, uart_bit_timer, which produces a one-cycle bit_end strobe every CLKS_PER_BIT cycles while enabled and clears when disabled.

Verification
REQ-027 Scenario: after reset, send tx_data=8'hA5 -> txd gives 0,1,0,1,0,0,1,0,1,1 at 16 cycles per bit; tx_done in cycle 161; tx_addr=1.
REQ-028 Scenario: send 8'h00 then 8'hFF with tx_valid held high -> the second start bit begins in cycle 162 and both frames are bit-exact.
REQ-029 Scenario: a loopback of txd into the existing 16x-oversampling receiver for 256 random bytes -> every received byte matches what was sent.
REQ-030 Scenario: preload tx_addr to 29999 by sending 29999 bytes, then send one more -> tx_addr goes to 0 at that byte's tx_done.
REQ-031 Scenario: assert rst in cycle 80 of a frame -> txd=1, tx_ready=1, tx_addr unchanged at 0, and no tx_done pulse.
REQ-032 Scenario: change tx_data during the DATA state, and assert tx_valid while busy -> the frame is unchanged, and no extra frame is sent.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types and constants for the transmitter and the receiver rework
//
// Contents:
//   DATA_BITS             payload bits per frame (8N1)
//   BIT_IDX_W             width of a bit index covering 0..DATA_BITS-1
//   CLKS_PER_BIT_DEFAULT  default clock cycles per serial bit
//   uart_state_t          frame FSM state encoding
//   addr_step             wrapping increment for the source read address

package uart_pkg;

    localparam int DATA_BITS            = 8;
    localparam int BIT_IDX_W            = $clog2(DATA_BITS);
    localparam int CLKS_PER_BIT_DEFAULT = 16;
    localparam int ADDR_W               = 15;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    // Next read address: wraps to 0 after the last valid location.
    function automatic logic [ADDR_W-1:0] addr_step(input logic [ADDR_W-1:0] addr,
                                                    input logic [ADDR_W-1:0] last);
        if (addr == last) begin
            return '0;
        end
        return addr + ADDR_W'(1);
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// rtl/uart_bit_timer.sv - bit-period timer producing a one-cycle strobe per serial bit
//
// Ports:
//   clk      clock, rising edge
//   rst      synchronous active-high reset
//   en       count while high; counter held at zero while low
//   bit_end  high for one cycle on the last clock of every bit period

module uart_bit_timer
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic bit_end
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt;

    // Holding the counter at zero while disabled means the first bit of a
    // frame gets a full period starting right after the enable rises.
    always_ff @(posedge clk) begin
        if (rst || !en) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign bit_end = en && (cnt == CNT_LAST);

endmodule

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - 8N1 UART transmitter with valid/ready byte input and source address counter
//
// Ports:
//   clk       clock, rising edge
//   rst       synchronous active-high reset
//   tx_data   byte to send, latched on acceptance
//   tx_valid  tx_data is valid
//   tx_ready  registered; high only while idle
//   txd       serial line, idle high, driven straight from a flop
//   tx_done   one-cycle pulse after each completed frame
//   tx_addr   count of bytes sent, wraps after ADDR_MAX

module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
    parameter int ADDR_MAX     = 29999
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              txd,
    output logic              tx_done,
    output logic [ADDR_W-1:0] tx_addr
);

    localparam logic [ADDR_W-1:0]    ADDR_LAST = ADDR_W'(ADDR_MAX);
    localparam logic [BIT_IDX_W-1:0] IDX_LAST  = BIT_IDX_W'(DATA_BITS - 1);

    uart_state_t          state;
    uart_state_t          state_next;
    logic [DATA_BITS-1:0] shreg;
    logic [DATA_BITS-1:0] shreg_next;
    logic [BIT_IDX_W-1:0] bit_idx;
    logic [BIT_IDX_W-1:0] bit_idx_next;
    logic                 txd_next;
    logic                 ready_next;
    logic                 done_next;
    logic [ADDR_W-1:0]    addr_next;
    logic                 accept;
    logic                 bit_end;
    logic                 last_bit;

    assign accept   = tx_valid && tx_ready;
    assign last_bit = (bit_idx == IDX_LAST);

    uart_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clk    (clk),
        .rst    (rst),
        .en     (state != IDLE),
        .bit_end(bit_end)
    );

    // State register plus every registered output, so txd, tx_ready and
    // tx_done never carry combinational glitches.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            shreg    <= '0;
            bit_idx  <= '0;
            txd      <= 1'b1;
            tx_ready <= 1'b1;
            tx_done  <= 1'b0;
            tx_addr  <= '0;
        end else begin
            state    <= state_next;
            shreg    <= shreg_next;
            bit_idx  <= bit_idx_next;
            txd      <= txd_next;
            tx_ready <= ready_next;
            tx_done  <= done_next;
            tx_addr  <= addr_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept)              state_next = START;
            START:   if (bit_end)             state_next = DATA;
            DATA:    if (bit_end && last_bit) state_next = STOP;
            STOP:    if (bit_end)             state_next = IDLE;
            default:                          state_next = IDLE;
        endcase
    end

    // Output/datapath logic: computes the value each output flop takes at
    // the coming edge, so the line changes exactly on bit boundaries.
    always_comb begin
        shreg_next   = shreg;
        bit_idx_next = bit_idx;
        txd_next     = txd;
        done_next    = 1'b0;
        addr_next    = tx_addr;
        ready_next   = (state_next == IDLE);
        case (state)
            IDLE: begin
                txd_next = 1'b1;
                if (accept) begin
                    shreg_next   = tx_data;
                    bit_idx_next = '0;
                    txd_next     = 1'b0;
                end
            end
            START: begin
                if (bit_end) begin
                    txd_next = shreg[0];
                end
            end
            DATA: begin
                // shreg[0] is the bit on the line; shreg[1] is the next one.
                if (bit_end) begin
                    shreg_next   = shreg >> 1;
                    bit_idx_next = bit_idx + BIT_IDX_W'(1);
                    txd_next     = last_bit ? 1'b1 : shreg[1];
                end
            end
            STOP: begin
                if (bit_end) begin
                    txd_next  = 1'b1;
                    done_next = 1'b1;
                    addr_next = addr_step(tx_addr, ADDR_LAST);
                end
            end
            default: begin
                txd_next = 1'b1;
            end
        endcase
    end

endmodule
